// File: rtl/cpu0_core.sv
// cpu0_core: 16-bit multi-cycle register CPU with a 16x16 register file, a four-flag
// ALU (c/z/v/s) and PC-relative branching. Instructions are fetched from an external
// combinational read-only program bus. A debug mux reads back PC, IR, flags or any
// register.
//
// Optional feature macro: CPU0_COND_JUMP_EN adds conditional relative jumps
// (0x44 JRC, 0x45 JRNC, 0x46 JRZ, 0x47 JRNZ). Without it, those opcodes are NOPs.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset; clears all state
//   data_bus     program word at address_bus
//   address_bus  program address, always equal to PC
//   wr           write strobe, constant 0 (no store instruction)
//   c, z, v, s   flag register: carry/borrow, zero, signed overflow, sign
//   sel          debug select: 00 PC, 01 IR, 10 flags, 11 R[reg_sel]
//   reg_sel      debug register index
//   reg_data     debug mux output (combinational)
module cpu0_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_bus,
  output logic [15:0] address_bus,
  output logic        wr,
  output logic        c,
  output logic        z,
  output logic        v,
  output logic        s,
  input  logic [1:0]  sel,
  input  logic [3:0]  reg_sel,
  output logic [15:0] reg_data
);

  typedef enum logic [1:0] {StFetch, StOpnd, StExec} state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] ir_q;
  logic [15:0] opr_q;
  logic [15:0] regs_q [16];
  logic        c_q, z_q, v_q, s_q;

  // Opcodes that carry a second (operand) word: MVRD and immediate ALU f=0..6.
  function automatic logic is_two_word(input logic [7:0] op);
    return (op == 8'h81) || ((op[7:4] == 4'hA) && (op[3:0] <= 4'd6));
  endfunction

  // Decode of the latched instruction.
  logic [7:0]  op;
  logic [3:0]  dr, sr, alu_f;
  logic        is_mvrd, is_alur, is_alui, is_alu, take_jump;
  logic [15:0] jump_target;

  assign op      = ir_q[15:8];
  assign dr      = ir_q[7:4];
  assign sr      = ir_q[3:0];
  assign alu_f   = op[3:0];
  assign is_mvrd = (op == 8'h81);
  assign is_alur = (op[7:4] == 4'h6) && (alu_f <= 4'd6);
  assign is_alui = (op[7:4] == 4'hA) && (alu_f <= 4'd6);
  assign is_alu  = is_alur || is_alui;
  // PC already points past the jump word when EXEC runs.
  assign jump_target = pc_q + {{8{ir_q[7]}}, ir_q[7:0]};

`ifdef CPU0_COND_JUMP_EN
  logic cond_ok;
  always_comb begin
    cond_ok = 1'b0;
    unique case (op[1:0])
      2'd0: cond_ok = c_q;
      2'd1: cond_ok = !c_q;
      2'd2: cond_ok = z_q;
      2'd3: cond_ok = !z_q;
    endcase
  end
  assign take_jump = (op == 8'h40) || ((op[7:2] == 6'b010001) && cond_ok);
`else
  assign take_jump = (op == 8'h40);
`endif

  // ALU
  logic [15:0] alu_a, alu_b, alu_res;
  logic [16:0] sum17, diff17;
  logic        alu_c, alu_v;

  assign alu_a  = regs_q[dr];
  assign alu_b  = is_alui ? opr_q : regs_q[sr];
  assign sum17  = {1'b0, alu_a} + {1'b0, alu_b};
  // Bit 16 of the widened difference is the unsigned borrow (A < B).
  assign diff17 = {1'b0, alu_a} - {1'b0, alu_b};

  always_comb begin
    alu_res = 16'h0000;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_f[2:0])
      3'd0: begin
        alu_res = sum17[15:0];
        alu_c   = sum17[16];
        alu_v   = (alu_a[15] == alu_b[15]) && (sum17[15] != alu_a[15]);
      end
      3'd1, 3'd6: begin
        alu_res = diff17[15:0];
        alu_c   = diff17[16];
        alu_v   = (alu_a[15] != alu_b[15]) && (diff17[15] != alu_a[15]);
      end
      3'd2:    alu_res = alu_a & alu_b;
      3'd3:    alu_res = alu_a | alu_b;
      3'd4:    alu_res = alu_a ^ alu_b;
      3'd5:    alu_res = alu_b;
      default: alu_res = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      pc_q    <= 16'h0000;
      ir_q    <= 16'h0000;
      opr_q   <= 16'h0000;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      s_q     <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= 16'h0000;
    end else begin
      unique case (state_q)
        StFetch: begin
          ir_q    <= data_bus;
          pc_q    <= pc_q + 16'd1;
          state_q <= is_two_word(data_bus[15:8]) ? StOpnd : StExec;
        end
        StOpnd: begin
          opr_q   <= data_bus;
          pc_q    <= pc_q + 16'd1;
          state_q <= StExec;
        end
        StExec: begin
          if (is_mvrd) regs_q[dr] <= opr_q;
          if (is_alu) begin
            if (alu_f != 4'd6) regs_q[dr] <= alu_res;
            c_q <= alu_c;
            z_q <= (alu_res == 16'h0000);
            v_q <= alu_v;
            s_q <= alu_res[15];
          end
          if (take_jump) pc_q <= jump_target;
          state_q <= StFetch;
        end
        default: state_q <= StFetch;
      endcase
    end
  end

  assign address_bus = pc_q;
  assign wr          = 1'b0;
  assign c           = c_q;
  assign z           = z_q;
  assign v           = v_q;
  assign s           = s_q;

  always_comb begin
    reg_data = 16'h0000;
    unique case (sel)
      2'b00: reg_data = pc_q;
      2'b01: reg_data = ir_q;
      2'b10: reg_data = {12'b0, c_q, z_q, v_q, s_q};
      2'b11: reg_data = regs_q[reg_sel];
    endcase
  end

endmodule

// File: tb/tb_cpu0_core.sv
// Directed testbench for cpu0_core: runs a small program from a combinational ROM and
// checks PC, registers, flags, IR and wr through the debug mux after each instruction.
module tb_cpu0_core;

  logic        clk;
  logic        reset;
  logic [15:0] data_bus;
  logic [15:0] address_bus;
  logic        wr;
  logic        c, z, v, s;
  logic [1:0]  sel;
  logic [3:0]  reg_sel;
  logic [15:0] reg_data;

  logic [15:0] mem [64];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  cpu0_core dut (
    .clk        (clk),
    .reset      (reset),
    .data_bus   (data_bus),
    .address_bus(address_bus),
    .wr         (wr),
    .c          (c),
    .z          (z),
    .v          (v),
    .s          (s),
    .sel        (sel),
    .reg_sel    (reg_sel),
    .reg_data   (reg_data)
  );

  assign data_bus = (address_bus < 16'd64) ? mem[address_bus[5:0]] : 16'h0000;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Read through the debug mux and compare.
  task automatic dbg(input string tag, input logic [1:0] s_in, input logic [3:0] r_in,
                     input logic [15:0] exp);
    sel     = s_in;
    reg_sel = r_in;
    #1;
    check(tag, reg_data, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[0]  = 16'h81F0; mem[1]  = 16'h01FF;  // R15 = 01FF
    mem[2]  = 16'h8100; mem[3]  = 16'h0002;  // R0  = 2
    mem[4]  = 16'h8120; mem[5]  = 16'h8000;  // R2  = 8000
    mem[6]  = 16'h8130; mem[7]  = 16'h0001;  // R3  = 1
    mem[8]  = 16'h8110; mem[9]  = 16'h0008;  // R1  = 8
    mem[10] = 16'h8140; mem[11] = 16'h0001;  // R4  = 1
    mem[12] = 16'h6131;                      // R3 = R3 - R1
    mem[13] = 16'h6142;                      // R4 = R4 - R2
    mem[14] = 16'h6022;                      // R2 = R2 + R2
    mem[15] = 16'hA100; mem[16] = 16'h0005;  // R0 = R0 - 5
    mem[17] = 16'hA200; mem[18] = 16'h0005;  // R0 &= 5
    mem[19] = 16'hA300; mem[20] = 16'h0F0F;  // R0 |= 0F0F
    mem[21] = 16'hA400; mem[22] = 16'h0F0F;  // R0 ^= 0F0F
    mem[23] = 16'hA500; mem[24] = 16'h0F0F;  // R0 = 0F0F
    mem[25] = 16'h8150; mem[26] = 16'h0001;  // R5 = 1
    mem[27] = 16'hA650; mem[28] = 16'h0001;  // CMP R5, 1
    mem[29] = 16'h4602;                      // JRZ +2 (z=1)
    mem[30] = 16'h8160; mem[31] = 16'h0005;  // R6 = 5
    mem[32] = 16'hA5E0; mem[33] = 16'h0001;  // R14 = 1, clears z
    mem[34] = 16'h4602;                      // JRZ +2 (z=0)
    mem[35] = 16'h8160; mem[36] = 16'h0007;  // R6 = 7
    mem[40] = 16'h7F00;                      // NOP
    mem[41] = 16'h8170; mem[42] = 16'h0002;  // R7 = 2
    mem[43] = 16'h40FC;                      // JR -4 -> 40

    sel = 2'b11; reg_sel = 4'd14;
    reset = 1'b0;
    #200;
    check("rst_addr", address_bus, 16'h0000);
    check("rst_flags", {12'b0, c, z, v, s}, 16'h0000);
    check("rst_wr", {15'b0, wr}, 16'h0000);
    dbg("rst_r14", 2'b11, 4'd14, 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    step(3);
    check("mvrd1_pc", address_bus, 16'd2);
    dbg("r15", 2'b11, 4'd15, 16'h01FF);
    step(3);
    check("mvrd2_pc", address_bus, 16'd4);
    dbg("r0", 2'b11, 4'd0, 16'h0002);
    step(12);
    check("mvrd6_pc", address_bus, 16'd12);
    dbg("r2", 2'b11, 4'd2, 16'h8000);
    dbg("r3", 2'b11, 4'd3, 16'h0001);

    step(2);
    check("sub_pc", address_bus, 16'd13);
    dbg("sub_r3", 2'b11, 4'd3, 16'hFFF9);
    dbg("sub_flags", 2'b10, 4'd0, 16'h0009);
    step(2);
    dbg("subv_r4", 2'b11, 4'd4, 16'h8001);
    dbg("subv_flags", 2'b10, 4'd0, 16'h000B);
    step(2);
    dbg("add_r2", 2'b11, 4'd2, 16'h0000);
    dbg("add_flags", 2'b10, 4'd0, 16'h000E);

    step(3);
    dbg("subi_r0", 2'b11, 4'd0, 16'hFFFD);
    dbg("subi_flags", 2'b10, 4'd0, 16'h0009);
    step(3);
    dbg("andi_r0", 2'b11, 4'd0, 16'h0005);
    dbg("andi_flags", 2'b10, 4'd0, 16'h0000);
    step(3);
    dbg("ori_r0", 2'b11, 4'd0, 16'h0F0F);
    step(3);
    dbg("xori_r0", 2'b11, 4'd0, 16'h0000);
    dbg("xori_flags", 2'b10, 4'd0, 16'h0004);
    step(3);
    dbg("movi_r0", 2'b11, 4'd0, 16'h0F0F);
    dbg("movi_flags", 2'b10, 4'd0, 16'h0000);
    step(6);
    check("cmp_pc", address_bus, 16'd29);
    dbg("cmp_r5", 2'b11, 4'd5, 16'h0001);
    dbg("cmp_flags", 2'b10, 4'd0, 16'h0004);

    step(2);
`ifdef CPU0_COND_JUMP_EN
    check("jrz_taken_pc", address_bus, 16'd32);
    dbg("jrz_taken_r6", 2'b11, 4'd6, 16'h0000);
`else
    check("jrz_nop_pc", address_bus, 16'd30);
    step(3);
    dbg("jrz_nop_r6", 2'b11, 4'd6, 16'h0005);
`endif
    step(3);
    dbg("r14", 2'b11, 4'd14, 16'h0001);
    step(2);
    check("jrz_fall_pc", address_bus, 16'd35);
    step(3);
    dbg("r6", 2'b11, 4'd6, 16'h0007);
    step(6);
    check("nops_pc", address_bus, 16'd40);

    for (int k = 0; k < 2; k++) begin
      step(2);
      check("loop_pc41", address_bus, 16'd41);
      step(3);
      check("loop_pc43", address_bus, 16'd43);
      dbg("loop_r7", 2'b11, 4'd7, 16'h0002);
      step(2);
      dbg("loop_pc40", 2'b00, 4'd0, 16'd40);
      dbg("loop_ir", 2'b01, 4'd0, 16'h40FC);
      dbg("loop_flags", 2'b10, 4'd0, 16'h0000);
      check("loop_wr", {15'b0, wr}, 16'h0000);
    end

    // Reset in the middle of a two-word instruction.
    step(3);
    reset = 1'b0;
    #1;
    check("midrst_addr", address_bus, 16'h0000);
    dbg("midrst_r7", 2'b11, 4'd7, 16'h0000);
    dbg("midrst_ir", 2'b01, 4'd0, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    step(3);
    check("post_rst_pc", address_bus, 16'd2);
    dbg("post_rst_r15", 2'b11, 4'd15, 16'h01FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
